bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: active-low levels, FSM states,
// tenure default and index widths.
package bus_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int unsigned MAX_TENURE_DEF = 16;
    localparam int unsigned OWNER_W        = 2;
    localparam int unsigned TENURE_W       = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder with optional fixed priority for
// requester 0. Requests are active high here.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] rr_ptr,
    input  logic               cpu_prio,
    output logic [OWNER_W-1:0] winner,
    output logic               found
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (cpu_prio && req[0]) begin
            found = 1'b1;
        end else begin
            // Walk from rr_ptr upward, wrapping; the first requester seen wins.
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = (32'(rr_ptr) + i) % NREQ;
                if (!found && (|(req & (NREQ'(1) << idx)))) begin
                    found  = 1'b1;
                    winner = OWNER_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared memory-bus arbiter: processor at index 0, DMA channels above it.
// Active-low request/grant handshake with tenure preemption and burst lock.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned MAX_TENURE = MAX_TENURE_DEF,
    parameter bit          CPU_PRIO   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic [NREQ-1:0]    req_,
    input  logic [NREQ-1:0]    lock_,
    output logic [NREQ-1:0]    gnt_,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_busy,
    output logic               preempt
);

    arb_state_e          state, state_n;
    logic [TENURE_W-1:0] tenure, tenure_n;
    logic [OWNER_W-1:0]  rr_ptr, rr_n, owner_n;
    logic [NREQ-1:0]     gnt_n;
    logic                busy_n, preempt_n;

    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     owner_bit;
    logic                owner_req, owner_locked, others_req, timed_out;
    logic [OWNER_W-1:0]  pick_winner;
    logic                pick_found;

    assign req          = ~req_;
    assign owner_bit    = NREQ'(1) << owner;
    assign owner_req    = |(req & owner_bit);
    assign owner_locked = |(~lock_ & owner_bit);
    assign others_req   = |(req & ~owner_bit);
    assign timed_out    = 32'(tenure) >= MAX_TENURE;

    bus_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .cpu_prio (CPU_PRIO),
        .winner   (pick_winner),
        .found    (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state    <= ARB_IDLE;
            tenure   <= '0;
            rr_ptr   <= '0;
            gnt_     <= {NREQ{DISABLE_}};
            owner    <= '0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            tenure   <= tenure_n;
            rr_ptr   <= rr_n;
            gnt_     <= gnt_n;
            owner    <= owner_n;
            bus_busy <= busy_n;
            preempt  <= preempt_n;
        end
    end

    always_comb begin
        state_n   = state;
        tenure_n  = tenure;
        rr_n      = rr_ptr;
        gnt_n     = gnt_;
        owner_n   = owner;
        busy_n    = bus_busy;
        preempt_n = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                gnt_n   = {NREQ{DISABLE_}};
                owner_n = '0;
                busy_n  = 1'b0;
                if (pick_found) begin
                    gnt_n    = ~(NREQ'(1) << pick_winner);
                    owner_n  = pick_winner;
                    busy_n   = 1'b1;
                    tenure_n = TENURE_W'(1);
                    rr_n     = (32'(pick_winner) + 32'd1 == NREQ) ? '0 : pick_winner + 1'b1;
                    state_n  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Release takes precedence over a coincident timeout.
                if (!owner_req) begin
                    gnt_n   = {NREQ{DISABLE_}};
                    owner_n = '0;
                    busy_n  = 1'b0;
                    state_n = ARB_IDLE;
                end else if (timed_out && !owner_locked && others_req) begin
                    gnt_n     = {NREQ{DISABLE_}};
                    owner_n   = '0;
                    busy_n    = 1'b0;
                    preempt_n = 1'b1;
                    state_n   = ARB_IDLE;
                end else if (tenure != '1) begin
                    tenure_n = tenure + 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios on two configurations
// plus randomized traffic compared against a rule-level reference model.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_;
    logic [2:0] req_a, lock_a, gnt_a, req_b, lock_b, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b, pre_a, pre_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int m_busy[2], m_owner[2], m_ten[2], m_rr[2], m_pre[2];

    always #5 clk = ~clk;

    bus_arbiter #(.NREQ(3), .MAX_TENURE(16), .CPU_PRIO(1'b1)) dut_a (
        .clk(clk), .reset_(reset_), .req_(req_a), .lock_(lock_a),
        .gnt_(gnt_a), .owner(owner_a), .bus_busy(busy_a), .preempt(pre_a)
    );

    bus_arbiter #(.NREQ(3), .MAX_TENURE(4), .CPU_PRIO(1'b0)) dut_b (
        .clk(clk), .reset_(reset_), .req_(req_b), .lock_(lock_b),
        .gnt_(gnt_b), .owner(owner_b), .bus_busy(busy_b), .preempt(pre_b)
    );

    task automatic model_step(input int k, input logic [2:0] rq_n, input logic [2:0] lk_n,
                              input int maxt, input int prio);
        logic [2:0] r;
        int w, c, o;
        bit others;
        r = ~rq_n;
        w = -1;
        others = 1'b0;
        if (!reset_) begin
            m_busy[k] = 0; m_owner[k] = 0; m_ten[k] = 0; m_rr[k] = 0; m_pre[k] = 0;
            return;
        end
        m_pre[k] = 0;
        if (m_busy[k] == 0) begin
            if (r != 3'b000) begin
                if (prio != 0 && r[0]) w = 0;
                else for (int j = 0; j < 3; j++) begin
                    c = (m_rr[k] + j) % 3;
                    if (w < 0 && r[c]) w = c;
                end
                m_busy[k] = 1; m_owner[k] = w; m_ten[k] = 1; m_rr[k] = (w + 1) % 3;
            end
        end else begin
            o = m_owner[k];
            for (int j = 0; j < 3; j++) if (j != o && r[j]) others = 1'b1;
            if (!r[o]) begin
                m_busy[k] = 0; m_owner[k] = 0;
            end else if (m_ten[k] >= maxt && lk_n[o] && others) begin
                m_busy[k] = 0; m_owner[k] = 0; m_pre[k] = 1;
            end else if (m_ten[k] < 255) begin
                m_ten[k] = m_ten[k] + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req_a, lock_a, 16, 1);
        model_step(1, req_b, lock_b, 4, 0);
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        tick();
        tick();
        checks++; if (gnt_a !== 3'b111) begin failures++; $display("FAIL reset_gnt_a got=%b exp=111", gnt_a); end
        checks++; if (busy_a !== 1'b0 || pre_a !== 1'b0 || owner_a !== 2'd0) begin
            failures++; $display("FAIL reset_outs_a busy=%b pre=%b owner=%0d exp=0/0/0", busy_a, pre_a, owner_a); end
        checks++; if (gnt_b !== 3'b111 || busy_b !== 1'b0 || pre_b !== 1'b0 || owner_b !== 2'd0) begin
            failures++; $display("FAIL reset_outs_b gnt=%b busy=%b pre=%b owner=%0d", gnt_b, busy_b, pre_b, owner_b); end
        reset_ = 1'b1;
    endtask

    task automatic test_cpu_hold();
        req_a = 3'b110;
        tick();
        checks++; if (gnt_a !== 3'b110 || owner_a !== 2'd0 || busy_a !== 1'b1) begin
            failures++; $display("FAIL cpu_first_grant gnt=%b owner=%0d busy=%b exp=110/0/1", gnt_a, owner_a, busy_a); end
        repeat (4) begin
            tick();
            checks++; if (gnt_a !== 3'b110) begin failures++; $display("FAIL cpu_hold gnt=%b exp=110", gnt_a); end
        end
        req_a = 3'b101;
        tick();
        checks++; if (gnt_a !== 3'b111 || busy_a !== 1'b0) begin
            failures++; $display("FAIL cpu_release_dead gnt=%b busy=%b exp=111/0", gnt_a, busy_a); end
        tick();
        checks++; if (gnt_a !== 3'b101 || owner_a !== 2'd1) begin
            failures++; $display("FAIL cpu_dead_one_cycle gnt=%b owner=%0d exp=101/1", gnt_a, owner_a); end
        req_a = 3'b111;
        tick();
    endtask

    task automatic test_cpu_prio_order();
        req_a = 3'b000;
        tick();
        checks++; if (gnt_a !== 3'b110 || owner_a !== 2'd0) begin
            failures++; $display("FAIL prio_cpu_wins gnt=%b owner=%0d exp=110/0", gnt_a, owner_a); end
        tick();
        req_a = 3'b001;
        tick();
        checks++; if (gnt_a !== 3'b111) begin failures++; $display("FAIL prio_dead0 gnt=%b exp=111", gnt_a); end
        tick();
        checks++; if (gnt_a !== 3'b101 || owner_a !== 2'd1) begin
            failures++; $display("FAIL prio_owner1 gnt=%b owner=%0d exp=101/1", gnt_a, owner_a); end
        req_a = 3'b011;
        tick();
        checks++; if (gnt_a !== 3'b111) begin failures++; $display("FAIL prio_dead1 gnt=%b exp=111", gnt_a); end
        tick();
        checks++; if (gnt_a !== 3'b011 || owner_a !== 2'd2) begin
            failures++; $display("FAIL prio_owner2 gnt=%b owner=%0d exp=011/2", gnt_a, owner_a); end
        req_a = 3'b111;
        tick();
    endtask

    task automatic test_rr_rotation();
        int seq[4] = '{0, 1, 2, 0};
        logic [2:0] exp_g;
        req_b = 3'b000;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_g = ~(3'b001 << seq[k]);
            checks++; if (gnt_b !== exp_g || owner_b !== 2'(seq[k]) || busy_b !== 1'b1) begin
                failures++; $display("FAIL rr_owner k=%0d gnt=%b owner=%0d exp=%b/%0d", k, gnt_b, owner_b, exp_g, seq[k]); end
            repeat (3) begin
                tick();
                checks++; if (gnt_b !== exp_g || pre_b !== 1'b0) begin
                    failures++; $display("FAIL rr_tenure k=%0d gnt=%b pre=%b exp=%b/0", k, gnt_b, pre_b, exp_g); end
            end
            tick();
            checks++; if (gnt_b !== 3'b111 || pre_b !== 1'b1 || busy_b !== 1'b0) begin
                failures++; $display("FAIL rr_preempt k=%0d gnt=%b pre=%b busy=%b exp=111/1/0", k, gnt_b, pre_b, busy_b); end
            if (k != 3) tick();
        end
        req_b = 3'b111;
        tick();
        checks++; if (pre_b !== 1'b0) begin failures++; $display("FAIL rr_pulse_width pre=%b exp=0", pre_b); end
    endtask

    task automatic test_lock();
        req_a  = 3'b101;
        lock_a = 3'b101;
        tick();
        checks++; if (gnt_a !== 3'b101 || owner_a !== 2'd1) begin
            failures++; $display("FAIL lock_grant gnt=%b owner=%0d exp=101/1", gnt_a, owner_a); end
        req_a = 3'b100;
        repeat (20) begin
            tick();
            checks++; if (gnt_a !== 3'b101 || pre_a !== 1'b0) begin
                failures++; $display("FAIL lock_hold gnt=%b pre=%b exp=101/0", gnt_a, pre_a); end
        end
        lock_a = 3'b111;
        tick();
        checks++; if (gnt_a !== 3'b111 || pre_a !== 1'b1) begin
            failures++; $display("FAIL lock_release_preempt gnt=%b pre=%b exp=111/1", gnt_a, pre_a); end
        tick();
        checks++; if (gnt_a !== 3'b110 || owner_a !== 2'd0 || pre_a !== 1'b0) begin
            failures++; $display("FAIL lock_cpu_next gnt=%b owner=%0d pre=%b exp=110/0/0", gnt_a, owner_a, pre_a); end
        req_a = 3'b111;
        tick();
    endtask

    task automatic test_release_at_timeout();
        req_a = 3'b011;
        tick();
        checks++; if (gnt_a !== 3'b011 || owner_a !== 2'd2) begin
            failures++; $display("FAIL rto_grant gnt=%b owner=%0d exp=011/2", gnt_a, owner_a); end
        req_a = 3'b001;
        repeat (15) begin
            tick();
            checks++; if (gnt_a !== 3'b011 || pre_a !== 1'b0) begin
                failures++; $display("FAIL rto_hold gnt=%b pre=%b exp=011/0", gnt_a, pre_a); end
        end
        req_a = 3'b101;
        tick();
        checks++; if (gnt_a !== 3'b111 || pre_a !== 1'b0) begin
            failures++; $display("FAIL rto_no_preempt gnt=%b pre=%b exp=111/0", gnt_a, pre_a); end
        tick();
        checks++; if (gnt_a !== 3'b101 || owner_a !== 2'd1 || pre_a !== 1'b0) begin
            failures++; $display("FAIL rto_next gnt=%b owner=%0d pre=%b exp=101/1/0", gnt_a, owner_a, pre_a); end
        req_a = 3'b111;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req_a = 3'b101;
        req_b = 3'b101;
        tick();
        checks++; if (owner_a !== 2'd1 || owner_b !== 2'd1 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++; $display("FAIL rmid_setup owner_a=%0d owner_b=%0d exp=1/1", owner_a, owner_b); end
        tick();
        reset_ = 1'b0;
        tick();
        checks++; if (gnt_a !== 3'b111 || busy_a !== 1'b0 || gnt_b !== 3'b111 || busy_b !== 1'b0) begin
            failures++; $display("FAIL rmid_abort gnt_a=%b busy_a=%b gnt_b=%b busy_b=%b", gnt_a, busy_a, gnt_b, busy_b); end
        reset_ = 1'b1;
        req_a  = 3'b000;
        req_b  = 3'b000;
        tick();
        checks++; if (owner_a !== 2'd0 || gnt_a !== 3'b110) begin
            failures++; $display("FAIL rmid_restart_a gnt=%b owner=%0d exp=110/0", gnt_a, owner_a); end
        checks++; if (owner_b !== 2'd0 || gnt_b !== 3'b110) begin
            failures++; $display("FAIL rmid_restart_b gnt=%b owner=%0d exp=110/0", gnt_b, owner_b); end
        req_a = 3'b111;
        req_b = 3'b111;
        tick();
    endtask

    task automatic test_random();
        logic [2:0] exp_g, prev_a, prev_b;
        prev_a = gnt_a;
        prev_b = gnt_b;
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 7) == 0) req_a[j]  = ~req_a[j];
                if ($urandom_range(0, 7) == 0) req_b[j]  = ~req_b[j];
                if ($urandom_range(0, 9) == 0) lock_a[j] = ~lock_a[j];
                if ($urandom_range(0, 9) == 0) lock_b[j] = ~lock_b[j];
            end
            reset_ = ($urandom_range(0, 127) != 0);
            tick();
            exp_g = (m_busy[0] != 0) ? ~(3'b001 << m_owner[0]) : 3'b111;
            checks++; if (gnt_a !== exp_g || busy_a !== (m_busy[0] != 0) || pre_a !== (m_pre[0] != 0)) begin
                failures++; $display("FAIL rand_a n=%0d gnt=%b busy=%b pre=%b exp=%b/%0d/%0d", n, gnt_a, busy_a, pre_a, exp_g, m_busy[0], m_pre[0]); end
            if (m_busy[0] != 0) begin
                checks++; if (owner_a !== 2'(m_owner[0])) begin
                    failures++; $display("FAIL rand_owner_a n=%0d got=%0d exp=%0d", n, owner_a, m_owner[0]); end
            end
            exp_g = (m_busy[1] != 0) ? ~(3'b001 << m_owner[1]) : 3'b111;
            checks++; if (gnt_b !== exp_g || busy_b !== (m_busy[1] != 0) || pre_b !== (m_pre[1] != 0)) begin
                failures++; $display("FAIL rand_b n=%0d gnt=%b busy=%b pre=%b exp=%b/%0d/%0d", n, gnt_b, busy_b, pre_b, exp_g, m_busy[1], m_pre[1]); end
            if (m_busy[1] != 0) begin
                checks++; if (owner_b !== 2'(m_owner[1])) begin
                    failures++; $display("FAIL rand_owner_b n=%0d got=%0d exp=%0d", n, owner_b, m_owner[1]); end
            end
            checks++; if ($countones(~gnt_a) > 1 || $countones(~gnt_b) > 1) begin
                failures++; $display("FAIL rand_onehot n=%0d gnt_a=%b gnt_b=%b", n, gnt_a, gnt_b); end
            checks++; if ((prev_a != 3'b111 && gnt_a != 3'b111 && gnt_a != prev_a) ||
                          (prev_b != 3'b111 && gnt_b != 3'b111 && gnt_b != prev_b)) begin
                failures++; $display("FAIL rand_dead_slot n=%0d a=%b->%b b=%b->%b", n, prev_a, gnt_a, prev_b, gnt_b); end
            prev_a = gnt_a;
            prev_b = gnt_b;
        end
    endtask

    initial begin
        reset_ = 1'b0;
        req_a  = 3'b111;
        req_b  = 3'b111;
        lock_a = 3'b111;
        lock_b = 3'b111;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_ten[k] = 0; m_rr[k] = 0; m_pre[k] = 0;
        end
        test_reset();
        test_cpu_hold();
        test_cpu_prio_order();
        test_rr_rotation();
        test_lock();
        test_release_at_timeout();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
